// File: rtl/pcs_channel_skew_injector.sv
`default_nettype none
// ============================================================================
// Module   : pcs_channel_skew_injector
// Purpose  : Delays each PMA-side lane by a programmable number of 66-bit
//            blocks so that RX deskew sees realistic inter-lane skew.
//            Optional sync-header corruption: define PCS_SH_ERROR_INJECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pcs_channel_skew_injector #(
    parameter int N_LANES     = 20,
    parameter int NB_DATA     = 66,
    parameter int MAX_SKEW    = 16,
    parameter int NB_SKEW     = $clog2(MAX_SKEW),
    parameter int NB_DATA_BUS = N_LANES * NB_DATA,
    parameter int NB_SKEW_BUS = N_LANES * NB_SKEW
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic [NB_DATA_BUS-1:0] i_data,
    input  logic                   i_rf_enable,
    input  logic [NB_SKEW_BUS-1:0] i_rf_skew_bus,
    input  logic                   i_rf_load_skew,
`ifdef PCS_SH_ERROR_INJECT_EN
    input  logic [N_LANES-1:0]     i_rf_sh_err_lane_mask,
    input  logic [15:0]            i_rf_sh_err_period,
    output logic [31:0]            o_sh_err_count,
`endif
    output logic [NB_DATA_BUS-1:0] o_data,
    output logic                   o_valid,
    output logic                   o_filling
);

    typedef enum logic [1:0] {
        ST_BYPASS = 2'd0,
        ST_FILL   = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    localparam logic [NB_SKEW:0]   c_max_skew  = (NB_SKEW+1)'(MAX_SKEW);
    localparam logic [NB_SKEW:0]   c_skew_max  = (NB_SKEW+1)'(MAX_SKEW - 1);
    localparam logic [NB_SKEW-1:0] c_ptr_last  = NB_SKEW'(MAX_SKEW - 1);
    localparam logic [NB_SKEW-1:0] c_fill_last = NB_SKEW'(MAX_SKEW - 2);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [NB_SKEW-1:0]       r_fill_cnt;
    logic [NB_SKEW-1:0]       w_fill_cnt_next;
    logic                     w_latch_skew;
    logic [NB_SKEW_BUS-1:0]   r_skew_bus;
    logic [NB_SKEW-1:0]       r_wr_ptr;
    logic [NB_DATA_BUS-1:0]   r_buf [MAX_SKEW];
    logic [NB_DATA_BUS-1:0]   w_skewed;
    logic [NB_DATA_BUS-1:0]   w_out;
    logic [NB_DATA_BUS-1:0]   r_data;
    logic                     r_valid;

    always_comb begin
        w_state_next    = r_state;
        w_fill_cnt_next = r_fill_cnt;
        w_latch_skew    = i_rf_load_skew;
        case (r_state)
            ST_BYPASS: begin
                if (i_rf_enable) begin
                    w_state_next    = ST_FILL;
                    w_fill_cnt_next = '0;
                    w_latch_skew    = 1'b1;
                end
            end
            ST_FILL: begin
                if (!i_rf_enable) begin
                    w_state_next = ST_BYPASS;
                end else if (i_rf_load_skew) begin
                    w_fill_cnt_next = '0;
                end else if (i_valid) begin
                    // The strobe that brings the count to MAX_SKEW-1 is the last fill block
                    if (r_fill_cnt == c_fill_last) begin
                        w_state_next = ST_RUN;
                    end else begin
                        w_fill_cnt_next = r_fill_cnt + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (!i_rf_enable) begin
                    w_state_next = ST_BYPASS;
                end else if (i_rf_load_skew) begin
                    w_state_next    = ST_FILL;
                    w_fill_cnt_next = '0;
                end
            end
            default: w_state_next = ST_BYPASS;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_valid) begin
            r_buf[r_wr_ptr] <= i_data;
        end
    end

    // Read index computed one bit wider so the modulo reduction is a single subtract
    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        logic [NB_SKEW:0] w_skew_ext;
        logic [NB_SKEW:0] w_skew_clamp;
        logic [NB_SKEW:0] w_rd_sum;
        logic [NB_SKEW:0] w_rd_idx;

        assign w_skew_ext   = {1'b0, r_skew_bus[k*NB_SKEW +: NB_SKEW]};
        assign w_skew_clamp = (w_skew_ext > c_skew_max) ? c_skew_max : w_skew_ext;
        assign w_rd_sum     = {1'b0, r_wr_ptr} + c_max_skew - w_skew_clamp;
        assign w_rd_idx     = (w_rd_sum >= c_max_skew) ? (w_rd_sum - c_max_skew) : w_rd_sum;
        assign w_skewed[k*NB_DATA +: NB_DATA] = (w_skew_clamp == '0)
                                              ? i_data[k*NB_DATA +: NB_DATA]
                                              : r_buf[w_rd_idx[NB_SKEW-1:0]][k*NB_DATA +: NB_DATA];
    end

`ifdef PCS_SH_ERROR_INJECT_EN
    logic [15:0] r_sh_cnt;
    logic [31:0] r_sh_err_count;
    logic [31:0] w_mask_pop;
    logic [32:0] w_err_sum;
    logic        w_inject;

    assign w_inject  = (r_state == ST_RUN) && i_valid && (i_rf_sh_err_period != 16'd0)
                    && (r_sh_cnt == i_rf_sh_err_period - 16'd1);
    assign w_err_sum = {1'b0, r_sh_err_count} + {1'b0, w_mask_pop};

    always_comb begin
        w_mask_pop = '0;
        for (int i = 0; i < N_LANES; i++) begin
            w_mask_pop = w_mask_pop + 32'(i_rf_sh_err_lane_mask[i]);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_sh_cnt       <= '0;
            r_sh_err_count <= '0;
        end else begin
            if ((r_state != ST_RUN) || (i_rf_sh_err_period == 16'd0)) begin
                r_sh_cnt <= '0;
            end else if (i_valid) begin
                r_sh_cnt <= w_inject ? 16'd0 : r_sh_cnt + 16'd1;
            end
            if (i_rf_sh_err_period == 16'd0) begin
                r_sh_err_count <= '0;
            end else if (w_inject) begin
                r_sh_err_count <= w_err_sum[32] ? '1 : w_err_sum[31:0];
            end
        end
    end

    assign o_sh_err_count = r_sh_err_count;
`endif

    always_comb begin
        w_out = (r_state == ST_BYPASS) ? i_data : w_skewed;
`ifdef PCS_SH_ERROR_INJECT_EN
        if (w_inject) begin
            for (int i = 0; i < N_LANES; i++) begin
                if (i_rf_sh_err_lane_mask[i]) begin
                    w_out[i*NB_DATA +: 2] = 2'b00;
                end
            end
        end
`endif
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= ST_BYPASS;
            r_fill_cnt <= '0;
            r_skew_bus <= '0;
            r_wr_ptr   <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_fill_cnt <= w_fill_cnt_next;
            if (w_latch_skew) begin
                r_skew_bus <= i_rf_skew_bus;
            end
            if (i_valid) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
                r_data   <= w_out;
            end
            r_valid <= i_valid && (r_state != ST_FILL);
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_filling = (r_state == ST_FILL);

endmodule
`default_nettype wire

// File: tb/tb_pcs_channel_skew_injector.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcs_channel_skew_injector
// Purpose  : Self-checking bench: bypass vector table plus a history-based
//            lane-lag model feeding an output scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcs_channel_skew_injector;
    localparam int N_LANES  = 20;
    localparam int NB_DATA  = 66;
    localparam int MAX_SKEW = 16;
    localparam int NB_SKEW  = 4;
    localparam int BUS      = N_LANES * NB_DATA;
    localparam int SBUS     = N_LANES * NB_SKEW;
    localparam int M_BYP = 0, M_FILL = 1, M_RUN = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            vld = 1'b0, en = 1'b0, ld = 1'b0;
    logic [BUS-1:0]  din = '0;
    logic [SBUS-1:0] skew_bus = '0;
    logic [BUS-1:0]  dout;
    logic            dvalid, dfill;
`ifdef PCS_SH_ERROR_INJECT_EN
    logic [N_LANES-1:0] mask = '0;
    logic [15:0]        period = '0;
    logic [31:0]        err_cnt;
    int                 m_sh = 0;
    longint             m_err = 0;
`endif

    always #5 clk = ~clk;

    pcs_channel_skew_injector dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_valid        (vld),
        .i_data         (din),
        .i_rf_enable    (en),
        .i_rf_skew_bus  (skew_bus),
        .i_rf_load_skew (ld),
`ifdef PCS_SH_ERROR_INJECT_EN
        .i_rf_sh_err_lane_mask (mask),
        .i_rf_sh_err_period    (period),
        .o_sh_err_count        (err_cnt),
`endif
        .o_data         (dout),
        .o_valid        (dvalid),
        .o_filling      (dfill)
    );

    typedef struct {
        logic           vld;
        logic [BUS-1:0] data;
        logic           exp_vld;
        logic [BUS-1:0] exp_data;
        logic           exp_fill;
    } vec_t;

    int             checks = 0, errors = 0;
    int             m_state, m_fill, gblk, cyc, fill_strobes;
    int             m_skew [N_LANES];
    logic [BUS-1:0] hist [0:4095];
    logic [BUS-1:0] exp_q [$];
    logic [BUS-1:0] m_last;
    bit             m_known, lag_chk, have3;
    logic [31:0]    prev3;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_bus(input string name, input logic [BUS-1:0] act, input logic [BUS-1:0] exp);
        int bad;
        checks++;
        if (act !== exp) begin
            errors++;
            bad = 0;
            for (int k = N_LANES - 1; k >= 0; k--)
                if (act[k*NB_DATA +: NB_DATA] !== exp[k*NB_DATA +: NB_DATA]) bad = k;
            $display("FAIL %s lane %0d: got %h expected %h", name, bad,
                     act[bad*NB_DATA +: NB_DATA], exp[bad*NB_DATA +: NB_DATA]);
        end
    endtask

    // Lane word: {lane index, block counter, 8'hA5, sync header}
    function automatic logic [BUS-1:0] mk_block(input int blk);
        logic [BUS-1:0] r;
        for (int k = 0; k < N_LANES; k++)
            r[k*NB_DATA +: NB_DATA] = {24'(k), 32'(blk), 8'hA5, 2'b01};
        return r;
    endfunction

    function automatic logic [31:0] lane_blk(input logic [BUS-1:0] b, input int k);
        logic [NB_DATA-1:0] w;
        w = b[k*NB_DATA +: NB_DATA];
        return w[41:10];
    endfunction

    function automatic logic [SBUS-1:0] mk_skew(input int mul, input int add);
        logic [SBUS-1:0] r;
        for (int k = 0; k < N_LANES; k++) r[k*NB_SKEW +: NB_SKEW] = 4'((k * mul + add) % MAX_SKEW);
        return r;
    endfunction

    task automatic model_reset();
        m_state = M_BYP; m_fill = 0; m_known = 1'b1; m_last = '0;
        for (int k = 0; k < N_LANES; k++) m_skew[k] = 0;
        exp_q.delete();
`ifdef PCS_SH_ERROR_INJECT_EN
        m_sh = 0; m_err = 0;
`endif
    endtask

    task automatic apply(input logic a_en, input logic a_ld, input logic a_vld, input logic [SBUS-1:0] a_skew);
        logic [BUS-1:0] blk, expb;
        logic           exp_v;
        int             nstate, idx;
        blk = a_vld ? mk_block(gblk) : ~mk_block(gblk);
        en = a_en; ld = a_ld; vld = a_vld; din = blk; skew_bus = a_skew;
        if (a_vld && dfill) fill_strobes++;
        exp_v = a_vld && (m_state != M_FILL);
        expb  = '0;
        if (a_vld) begin
            hist[gblk] = blk;
            for (int k = 0; k < N_LANES; k++) begin
                idx = gblk - m_skew[k];
                if (m_state == M_BYP) expb[k*NB_DATA +: NB_DATA] = blk[k*NB_DATA +: NB_DATA];
                else if (idx >= 0)    expb[k*NB_DATA +: NB_DATA] = hist[idx][k*NB_DATA +: NB_DATA];
            end
`ifdef PCS_SH_ERROR_INJECT_EN
            if (m_state == M_RUN && period != 0) begin
                if (m_sh == int'(period) - 1) begin
                    m_sh = 0;
                    for (int k = 0; k < N_LANES; k++)
                        if (mask[k]) begin expb[k*NB_DATA +: 2] = 2'b00; m_err++; end
                    if (m_err > 64'hFFFF_FFFF) m_err = 64'hFFFF_FFFF;
                end else m_sh++;
            end
`endif
            if (exp_v) begin exp_q.push_back(expb); m_known = 1'b1; m_last = expb; end
            else m_known = 1'b0;
            gblk++;
        end
`ifdef PCS_SH_ERROR_INJECT_EN
        if (m_state != M_RUN || period == 0) m_sh = 0;
        if (period == 0) m_err = 0;
`endif
        nstate = m_state;
        case (m_state)
            M_BYP:  if (a_en) begin nstate = M_FILL; m_fill = 0; end
            M_FILL: if (!a_en) nstate = M_BYP;
                    else if (a_ld) m_fill = 0;
                    else if (a_vld) begin
                        if (m_fill == MAX_SKEW - 2) nstate = M_RUN; else m_fill++;
                    end
            default: if (!a_en) nstate = M_BYP;
                     else if (a_ld) begin nstate = M_FILL; m_fill = 0; end
        endcase
        if (a_ld || (m_state == M_BYP && a_en))
            for (int k = 0; k < N_LANES; k++) m_skew[k] = int'(a_skew[k*NB_SKEW +: NB_SKEW]);
        m_state = nstate;

        @(posedge clk); #1;
        chk("o_valid", dvalid, exp_v);
        chk("o_filling", dfill, m_state == M_FILL);
`ifdef PCS_SH_ERROR_INJECT_EN
        chk("o_sh_err_count", err_cnt, m_err[31:0]);
`endif
        if (dvalid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard: o_valid with no expected block");
            end else begin
                expb = exp_q.pop_front();
                chk_bus("o_data", dout, expb);
                if (lag_chk) begin
                    chk("lag lane15", lane_blk(dout, 0) - lane_blk(dout, 15), 15);
                    chk("lag lane16", lane_blk(dout, 0) - lane_blk(dout, 16), 0);
                    if (have3) chk("lane3 sequence", lane_blk(dout, 3), prev3 + 1);
                    prev3 = lane_blk(dout, 3); have3 = 1'b1;
                end
            end
        end else begin
            if (exp_v && exp_q.size() != 0) void'(exp_q.pop_back());
            if (m_known) chk_bus("o_data hold", dout, m_last);
        end
    endtask

    task automatic run(input int n, input logic a_en, input logic [SBUS-1:0] s);
        int  done;
        logic v;
        done = 0;
        while (done < n) begin
            v = ((cyc % 4) != 3);
            cyc++;
            apply(a_en, 1'b0, v, s);
            if (v) done++;
        end
    endtask

    initial begin
        vec_t           tbl [10];
        logic [BUS-1:0] prev;
        logic [SBUS-1:0] sk0, sk1, sk2;

        prev = '0;
        for (int i = 0; i < 10; i++) begin
            tbl[i].vld      = (i % 2 == 0);
            tbl[i].data     = mk_block(1000 + i);
            tbl[i].exp_vld  = tbl[i].vld;
            tbl[i].exp_data = tbl[i].vld ? tbl[i].data : prev;
            tbl[i].exp_fill = 1'b0;
            prev = tbl[i].exp_data;
        end
        sk0 = '0;
        sk1 = mk_skew(1, 0);
        sk2 = mk_skew(7, 3);
        gblk = 0; cyc = 0; fill_strobes = 0; lag_chk = 0; have3 = 0; prev3 = '0;
        model_reset();

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset o_data", (dout == '0), 1);
        chk("reset o_valid", dvalid, 0);
        chk("reset o_filling", dfill, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            en = 1'b0; ld = 1'b0; vld = tbl[i].vld; din = tbl[i].data;
            @(posedge clk); #1;
            chk("tbl o_valid", dvalid, tbl[i].exp_vld);
            chk("tbl o_filling", dfill, tbl[i].exp_fill);
            chk_bus("tbl o_data", dout, tbl[i].exp_data);
        end
        m_last = tbl[9].exp_data; m_known = 1'b1;

        // All-zero skews: fill then one-clock pass-through
        fill_strobes = 0;
        apply(1'b1, 1'b0, 1'b1, sk0);
        run(30, 1'b1, sk0);
        chk("fill strobes skew0", fill_strobes, 15);

        // Lane k skew = k mod 16, long enough to wrap the write pointer 3+ times
        fill_strobes = 0;
        apply(1'b1, 1'b1, 1'b1, sk1);
        run(15, 1'b1, sk1);
        chk("fill strobes reload", fill_strobes, 15);
        lag_chk = 1'b1; have3 = 1'b0;
        run(55, 1'b1, sk1);
        lag_chk = 1'b0;

        fill_strobes = 0;
        apply(1'b1, 1'b1, 1'b1, sk2);
        run(15, 1'b1, sk2);
        chk("fill strobes new skews", fill_strobes, 15);
        run(20, 1'b1, sk2);

        // Load together with disable: straight to bypass
        apply(1'b0, 1'b1, 1'b1, sk1);
        chk("load+disable bypass", dfill, 0);
        run(6, 1'b0, sk1);

        // Load mid-fill restarts the count
        fill_strobes = 0;
        apply(1'b1, 1'b0, 1'b1, sk1);
        run(5, 1'b1, sk1);
        apply(1'b1, 1'b1, 1'b1, sk2);
        run(15, 1'b1, sk2);
        chk("fill strobes restart", fill_strobes, 21);
        run(10, 1'b1, sk2);

`ifdef PCS_SH_ERROR_INJECT_EN
        mask = 20'h00005; period = 16'd8;
        run(8, 1'b1, sk2);
        chk("sh err after first", err_cnt, 2);
        run(16, 1'b1, sk2);
        chk("sh err after third", err_cnt, 6);
        period = 16'd0;
        run(10, 1'b1, sk2);
        chk("sh err disabled", err_cnt, 0);
`endif

        // Asynchronous reset mid-run
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async rst o_valid", dvalid, 0);
        chk("async rst o_data", (dout == '0), 1);
        chk("async rst o_filling", dfill, 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        apply(1'b0, 1'b0, 1'b0, sk0);
        run(6, 1'b0, sk0);

        chk("scoreboard empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
